// File: rtl/tt_um_moving_average_master_pkg.sv
// Shared constants for the moving-average tile.
// Contents: data/sum widths, history depth, filter_select encoding and
// helpers that turn a filter_select code into a window length and shift.
package tt_um_moving_average_master_pkg;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned MAX_TAPS = 16;
  localparam int unsigned SUM_W    = 14;

  typedef enum logic [1:0] {
    SelTaps2  = 2'b00,
    SelTaps4  = 2'b01,
    SelTaps8  = 2'b10,
    SelTaps16 = 2'b11
  } filter_sel_e;

  // Window length: 2, 4, 8 or 16.
  function automatic logic [4:0] sel_taps(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction

  // log2 of the window length, used to divide the sum.
  function automatic logic [2:0] sel_shift(input logic [1:0] sel);
    return {1'b0, sel} + 3'd1;
  endfunction

endpackage

// File: rtl/moving_average_core.sv
// Moving-average filter core: 16-entry sample history, masked adder and
// registered output with a one-cycle result strobe.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_strobe  capture i_sample into the history this cycle
//   i_sample  sample value
//   i_sel     filter_select (window length 2/4/8/16)
//   o_data    latest average, held between strobes
//   o_strobe  one-cycle pulse when o_data has just been updated
module moving_average_core #(
  parameter int unsigned DATA_W   = tt_um_moving_average_master_pkg::DATA_W,
  parameter int unsigned MAX_TAPS = tt_um_moving_average_master_pkg::MAX_TAPS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_strobe,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [1:0]        i_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_strobe
);

  import tt_um_moving_average_master_pkg::*;

  logic [DATA_W-1:0] r_hist [MAX_TAPS];
  logic              r_pending;
  logic [DATA_W-1:0] r_data;
  logic              r_strobe;

  logic [4:0]        w_taps;
  logic [2:0]        w_shift;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_avg;

  assign w_taps  = sel_taps(i_sel);
  assign w_shift = sel_shift(i_sel);

  // Sum only the newest w_taps entries; r_hist[0] is the newest sample.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (5'(i) < w_taps) begin
        w_sum = w_sum + SUM_W'(r_hist[i]);
      end
    end
  end

  assign w_avg = w_sum >> w_shift;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        r_hist[i] <= '0;
      end
    end else if (i_strobe) begin
      r_hist[0] <= i_sample;
      for (int i = 1; i < MAX_TAPS; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // The average is taken one edge after capture so the new sample is in the
  // history; filter_select is therefore sampled at that later edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_data    <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_pending <= i_strobe;
      r_strobe  <= r_pending;
      if (r_pending) begin
        r_data <= w_avg[DATA_W-1:0];
      end
    end
  end

  assign o_data   = r_data;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/tt_um_moving_average_master.sv
// Tiny Tapeout wrapper for the moving-average filter. Maps pins onto
// moving_average_core and drives constant output enables.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   ena         tile enable (unused)
//   ui_in       sample[7:0]
//   uio_in      [7:6] filter_select, [3:2] sample[9:8], [0] strobe_in
//   uo_out      average[7:0]
//   uio_out     [5:4] average[9:8], [1] strobe_out, others 0
//   uio_oe      constant 8'b0011_0010
module tt_um_moving_average_master #(
  parameter int unsigned DATA_W   = tt_um_moving_average_master_pkg::DATA_W,
  parameter int unsigned MAX_TAPS = tt_um_moving_average_master_pkg::MAX_TAPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tt_um_moving_average_master_pkg::*;

  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] w_data;
  logic              w_strobe;
  logic              w_unused;

  assign w_sample = DATA_W'({uio_in[3:2], ui_in});

  moving_average_core #(
    .DATA_W  (DATA_W),
    .MAX_TAPS(MAX_TAPS)
  ) u_core (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_strobe(uio_in[0]),
    .i_sample(w_sample),
    .i_sel   (uio_in[7:6]),
    .o_data  (w_data),
    .o_strobe(w_strobe)
  );

  assign uo_out  = w_data[7:0];
  assign uio_out = {2'b00, w_data[9:8], 2'b00, w_strobe, 1'b0};
  assign uio_oe  = 8'b0011_0010;

  assign w_unused = &{1'b0, ena, uio_in[5:4], uio_in[1]};

endmodule

// File: tb/tb_tt_um_moving_average_master.sv
module tb_tt_um_moving_average_master;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;

  // Reference state: newest sample at index 0, averages computed on demand.
  int hist_q[$];
  bit pending;
  int exp_out;
  bit exp_stb;

  tt_um_moving_average_master dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_avg(input int sel);
    int n;
    int s;
    n = 2 << sel;
    s = 0;
    for (int i = 0; i < n; i++) begin
      if (i < hist_q.size()) s += hist_q[i];
    end
    return s / n;
  endfunction

  function automatic int dut_avg();
    return int'({uio_out[5:4], uo_out});
  endfunction

  // One clock: apply inputs, step the model, check every output.
  task automatic cyc(input bit rst, input bit stb, input int sel, input int smp);
    rst_n  = ~rst;
    ui_in  = smp[7:0];
    uio_in = {sel[1:0], 2'($urandom_range(0, 3)), smp[9:8], 1'($urandom_range(0, 1)), stb};
    ena    = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if (rst) begin
      hist_q.delete();
      pending = 0;
      exp_out = 0;
      exp_stb = 0;
    end else begin
      exp_stb = pending;
      if (pending) exp_out = model_avg(sel);
      if (stb) begin
        hist_q.push_front(smp);
        if (hist_q.size() > 16) void'(hist_q.pop_back());
      end
      pending = stb;
    end
    check_eq("average", dut_avg(), exp_out);
    check_eq("strobe_out", uio_out[1], exp_stb);
    check_eq("uio_oe", uio_oe, 8'b0011_0010);
    check_eq("uio_out_unused", uio_out & 8'b1100_1101, 0);
  endtask

  task automatic strobe_get(input int sel, input int smp, output int avg);
    cyc(0, 1, sel, smp);
    cyc(0, 0, sel, 0);
    avg = dut_avg();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 555);
  endtask

  initial begin
    int avg;
    int n127;
    int sel;
    checks   = 0;
    failures = 0;
    pending  = 0;
    exp_out  = 0;
    exp_stb  = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = '0;
    uio_in   = '0;

    do_reset();
    check_eq("reset_data", dut_avg(), 0);
    check_eq("reset_strobe", uio_out[1], 0);

    // Impulse through an 8-tap window.
    n127 = 0;
    for (int k = 0; k < 50; k++) begin
      strobe_get(2, (k == 10) ? 1023 : 0, avg);
      if (avg == 127) n127++;
      if (k == 9)  check_eq("impulse_pre", avg, 0);
      if (k == 10) check_eq("impulse_peak", avg, 127);
      if (k == 18) check_eq("impulse_post", avg, 0);
    end
    check_eq("impulse_count127", n127, 8);
    check_eq("impulse_tail", avg, 0);

    // Step into a 2-tap window.
    do_reset();
    strobe_get(0, 1023, avg);
    check_eq("step_first", avg, 511);
    for (int k = 0; k < 4; k++) begin
      strobe_get(0, 1023, avg);
      check_eq("step_hold", avg, 1023);
    end

    // Ramp-up through a 16-tap window.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      strobe_get(3, 100, avg);
      check_eq("ramp", avg, (100 * ((k > 16) ? 16 : k)) / 16);
    end

    // Window switch keeps history.
    do_reset();
    strobe_get(1, 4, avg);
    strobe_get(1, 8, avg);
    strobe_get(1, 12, avg);
    strobe_get(1, 16, avg);
    check_eq("sel4_avg", avg, 10);
    strobe_get(0, 20, avg);
    check_eq("sel2_avg", avg, 18);

    // Reset discards history.
    do_reset();
    for (int k = 0; k < 8; k++) strobe_get(2, 800, avg);
    check_eq("pre_reset_avg", avg, 800);
    cyc(0, 1, 2, 800);
    cyc(1, 0, 2, 0);
    check_eq("reset_strobe_low", uio_out[1], 0);
    check_eq("reset_data_low", dut_avg(), 0);
    strobe_get(2, 800, avg);
    check_eq("post_reset_avg", avg, 100);

    // Continuous strobes: strobe_out every cycle, one cycle late.
    for (int k = 0; k < 24; k++) cyc(0, 1, 3, int'($urandom_range(0, 1023)));
    cyc(0, 0, 3, 0);
    cyc(0, 0, 3, 0);

    // Randomised traffic with occasional resets and window changes.
    sel = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) sel = int'($urandom_range(0, 3));
      cyc($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), sel,
          int'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
